// File: rtl/rot_imm_encoder_if.sv
// Request/result handshake bundle for the rotated-immediate encoder.
// The slave side is the encoder. The master side is the requester and consumer.
interface rot_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic        allow_invert;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_imm8;
  logic [3:0]  out_rotate;
  logic        out_inverted;
  logic        out_fail;

  modport slave (
    input  in_valid, value, allow_invert, out_ready,
    output in_ready, out_valid, out_imm8, out_rotate, out_inverted, out_fail
  );

  modport master (
    output in_valid, value, allow_invert, out_ready,
    input  in_ready, out_valid, out_imm8, out_rotate, out_inverted, out_fail
  );
endinterface

// File: rtl/rot_imm_encoder.sv
// Finds the canonical (imm8, rotate_imm) pair with value == imm8 ROR (2*rotate_imm).
// Each cycle tests one rotation. An optional second pass searches ~value for MVN.
module rot_imm_encoder #(
  parameter bit ENABLE_INVERT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  rot_imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_SEARCH_INV, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_work, w_work_nxt;
  logic        r_allow, w_allow_nxt;
  logic [3:0]  r_rot, w_rot_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [7:0]  r_imm8, w_imm8_nxt;
  logic [3:0]  r_rotate, w_rotate_nxt;
  logic        r_inverted, w_inverted_nxt;
  logic        r_fail, w_fail_nxt;

  logic [5:0]  w_amt;
  logic [31:0] w_rol;
  logic        w_match;
  logic        w_can_inv;

  // A shift by 32 yields zero, so the r=0 case needs no special handling.
  assign w_amt     = {1'b0, r_rot, 1'b0};
  assign w_rol     = (r_work << w_amt) | (r_work >> (6'd32 - w_amt));
  assign w_match   = (w_rol[31:8] == 24'd0);
  assign w_can_inv = ENABLE_INVERT && r_allow;

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_allow_nxt     = r_allow;
    w_rot_nxt       = r_rot;
    w_out_valid_nxt = r_out_valid;
    w_imm8_nxt      = r_imm8;
    w_rotate_nxt    = r_rotate;
    w_inverted_nxt  = r_inverted;
    w_fail_nxt      = r_fail;

    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_work_nxt  = bus.value;
          w_allow_nxt = bus.allow_invert;
          w_rot_nxt   = 4'd0;
          w_state_nxt = S_SEARCH;
        end
      end
      S_SEARCH, S_SEARCH_INV: begin
        if (w_match) begin
          w_imm8_nxt      = w_rol[7:0];
          w_rotate_nxt    = r_rot;
          w_inverted_nxt  = (r_state == S_SEARCH_INV);
          w_fail_nxt      = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else if (r_rot != 4'd15) begin
          w_rot_nxt = r_rot + 4'd1;
        end else if ((r_state == S_SEARCH) && w_can_inv) begin
          w_work_nxt  = ~r_work;
          w_rot_nxt   = 4'd0;
          w_state_nxt = S_SEARCH_INV;
        end else begin
          w_imm8_nxt      = 8'd0;
          w_rotate_nxt    = 4'd0;
          w_inverted_nxt  = 1'b0;
          w_fail_nxt      = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        // Result fields stay put after the handshake; only valid drops.
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_work      <= 32'd0;
      r_allow     <= 1'b0;
      r_rot       <= 4'd0;
      r_out_valid <= 1'b0;
      r_imm8      <= 8'd0;
      r_rotate    <= 4'd0;
      r_inverted  <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_allow     <= w_allow_nxt;
      r_rot       <= w_rot_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_imm8      <= w_imm8_nxt;
      r_rotate    <= w_rotate_nxt;
      r_inverted  <= w_inverted_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  assign bus.in_ready     = (r_state == S_IDLE);
  assign bus.out_valid    = r_out_valid;
  assign bus.out_imm8     = r_imm8;
  assign bus.out_rotate   = r_rotate;
  assign bus.out_inverted = r_inverted;
  assign bus.out_fail     = r_fail;

endmodule

// File: tb/tb_rot_imm_encoder.sv
// Directed bench for rot_imm_encoder: table vectors plus backpressure and async-reset sequences.
// The dut_a instance searches the inverse. The dut_b instance has the inverse search disabled.
module tb_rot_imm_encoder;

  logic clk;
  logic rst;

  rot_imm_encoder_if if_a ();
  rot_imm_encoder_if if_b ();

  rot_imm_encoder #(.ENABLE_INVERT(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  rot_imm_encoder #(.ENABLE_INVERT(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Selects which instance is driven and observed.
  logic       sel;
  logic       o_in_ready, o_out_valid, o_inverted, o_fail;
  logic [7:0] o_imm8;
  logic [3:0] o_rotate;

  always_comb begin
    o_in_ready  = sel ? if_b.in_ready     : if_a.in_ready;
    o_out_valid = sel ? if_b.out_valid    : if_a.out_valid;
    o_imm8      = sel ? if_b.out_imm8     : if_a.out_imm8;
    o_rotate    = sel ? if_b.out_rotate   : if_a.out_rotate;
    o_inverted  = sel ? if_b.out_inverted : if_a.out_inverted;
    o_fail      = sel ? if_b.out_fail     : if_a.out_fail;
  end

  typedef struct {
    logic        sel;
    logic [31:0] value;
    logic        allow;
    logic [7:0]  imm8;
    logic [3:0]  rot;
    logic        inv;
    logic        fail;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive_idle();
    if_a.in_valid = 1'b0; if_a.value = 32'd0; if_a.allow_invert = 1'b0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.value = 32'd0; if_b.allow_invert = 1'b0; if_b.out_ready = 1'b0;
  endtask

  // Presents a request, then counts edges after the accept edge until out_valid rises.
  task automatic request(input logic s, input logic [31:0] v, input logic a, output int lat);
    @(negedge clk);
    sel = s;
    #0;
    check("in_ready_before_req", {31'd0, o_in_ready}, 32'd1);
    if_a.in_valid = ~s; if_a.value = v; if_a.allow_invert = a;
    if_b.in_valid = s;  if_b.value = v; if_b.allow_invert = a;
    @(posedge clk);
    #1;
    if_a.in_valid = 1'b0;
    if_b.in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (o_out_valid) break;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, o_out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, o_in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] hold_imm8;
    logic [3:0] hold_rot;

    //          sel   value          allow imm8   rot   inv   fail  lat
    vecs[0]  = '{1'b0, 32'h0000_00FF, 1'b0, 8'hFF, 4'd0, 1'b0, 1'b0, 1};
    vecs[1]  = '{1'b0, 32'hFF00_0000, 1'b0, 8'hFF, 4'd4, 1'b0, 1'b0, 5};
    vecs[2]  = '{1'b0, 32'hF000_000F, 1'b0, 8'hFF, 4'd2, 1'b0, 1'b0, 3};
    vecs[3]  = '{1'b0, 32'h0000_03FC, 1'b0, 8'hFF, 4'd15, 1'b0, 1'b0, 16};
    vecs[4]  = '{1'b0, 32'hFFFF_FF00, 1'b1, 8'hFF, 4'd0, 1'b1, 1'b0, 17};
    vecs[5]  = '{1'b0, 32'hFFFF_FF00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 16};
    vecs[6]  = '{1'b1, 32'hFFFF_FF00, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 16};
    vecs[7]  = '{1'b0, 32'h0001_2345, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 32};
    vecs[8]  = '{1'b0, 32'h0000_0000, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1};
    vecs[9]  = '{1'b0, 32'h00FF_FFFF, 1'b1, 8'hFF, 4'd4, 1'b1, 1'b0, 21};
    vecs[10] = '{1'b1, 32'h0000_3FC0, 1'b1, 8'hFF, 4'd13, 1'b0, 1'b0, 14};

    sel = 1'b0;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    check("rst_imm8", {24'd0, o_imm8}, 32'd0);
    check("rst_fail", {31'd0, o_fail}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      request(vecs[i].sel, vecs[i].value, vecs[i].allow, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_imm8", i), {24'd0, o_imm8}, {24'd0, vecs[i].imm8});
      check($sformatf("v%0d_rotate", i), {28'd0, o_rotate}, {28'd0, vecs[i].rot});
      check($sformatf("v%0d_inverted", i), {31'd0, o_inverted}, {31'd0, vecs[i].inv});
      check($sformatf("v%0d_fail", i), {31'd0, o_fail}, {31'd0, vecs[i].fail});
      release_result($sformatf("v%0d", i));
    end

    // Backpressure, with stray in_valid pulses during search and while holding the result.
    sel = 1'b0;
    @(negedge clk);
    if_a.in_valid = 1'b1; if_a.value = 32'hFF00_0000; if_a.allow_invert = 1'b0;
    @(posedge clk);
    #1;
    if_a.value = 32'h0000_0001;
    @(posedge clk);
    #1;
    check("bp_in_ready_search", {31'd0, o_in_ready}, 32'd0);
    if_a.in_valid = 1'b0;
    lat = 1;
    while (lat < 40 && !o_out_valid) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_latency", lat, 5);
    if_a.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_valid", c), {31'd0, o_out_valid}, 32'd1);
      check($sformatf("bp_hold%0d_imm8", c), {24'd0, o_imm8}, 32'h0000_00FF);
      check($sformatf("bp_hold%0d_rotate", c), {28'd0, o_rotate}, 32'd4);
      check($sformatf("bp_hold%0d_in_ready", c), {31'd0, o_in_ready}, 32'd0);
    end
    if_a.in_valid = 1'b0;
    release_result("bp");
    check("bp_imm8_kept", {24'd0, o_imm8}, 32'h0000_00FF);
    check("bp_rotate_kept", {28'd0, o_rotate}, 32'd4);
    @(posedge clk);
    #1;
    check("bp_no_queued_req", {31'd0, o_in_ready}, 32'd1);

    // Asynchronous reset mid-search at r=7, then a fresh request.
    @(negedge clk);
    if_a.in_valid = 1'b1; if_a.value = 32'h0001_2345; if_a.allow_invert = 1'b0;
    @(posedge clk);
    #1;
    if_a.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, o_out_valid}, 32'd0);
    check("arst_imm8", {24'd0, o_imm8}, 32'd0);
    check("arst_rotate", {28'd0, o_rotate}, 32'd0);
    check("arst_inverted", {31'd0, o_inverted}, 32'd0);
    check("arst_fail", {31'd0, o_fail}, 32'd0);
    check("arst_in_ready", {31'd0, o_in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    request(1'b0, 32'h0000_00FF, 1'b0, lat);
    check("post_rst_latency", lat, 1);
    check("post_rst_imm8", {24'd0, o_imm8}, 32'h0000_00FF);
    check("post_rst_rotate", {28'd0, o_rotate}, 32'd0);
    check("post_rst_fail", {31'd0, o_fail}, 32'd0);
    release_result("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
